// File: rtl/buf_ram_1p_arb.sv
// Round-robin arbiter between the coefficient writer and reader for the single-port
// 192x64 buffer RAM, with a two-stage read pipeline and out-of-range address screening.
module buf_ram_1p_arb #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 192
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_gnt,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_gnt,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  ram_ce,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  err_addr,
   output logic                  busy
);

   typedef enum logic {SIDE_WR = 1'b0, SIDE_RD = 1'b1} side_t;

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   side_t                 r_last;
   logic                  r_s1_valid;
   logic                  r_s1_oor;
   logic                  r_s2_valid;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_err_addr;

   logic w_wr_gnt;
   logic w_rd_gnt;
   logic w_wr_ok;
   logic w_rd_ok;

   assign w_wr_ok = ({1'b0, wr_addr} < DEPTH_W);
   assign w_rd_ok = ({1'b0, rd_addr} < DEPTH_W);

   // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      w_wr_gnt = 1'b0;
      w_rd_gnt = 1'b0;
      if (!rst) begin
         if (wr_req && rd_req) begin
            // Conflict: the side that did not win last time goes now.
            w_wr_gnt = (r_last == SIDE_RD);
            w_rd_gnt = (r_last == SIDE_WR);
         end else begin
            w_wr_gnt = wr_req;
            w_rd_gnt = rd_req;
         end
      end
   end

   always_comb begin
      ram_ce    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (w_wr_gnt) begin
         ram_ce    = w_wr_ok;
         ram_we    = w_wr_ok;
         ram_addr  = wr_addr;
         ram_wdata = wr_data;
      end else if (w_rd_gnt) begin
         ram_ce   = w_rd_ok;
         ram_addr = rd_addr;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last     <= SIDE_RD;
         r_s1_valid <= 1'b0;
         r_s1_oor   <= 1'b0;
         r_s2_valid <= 1'b0;
         r_rd_data  <= '0;
         r_err_addr <= 1'b0;
      end else begin
         if (w_wr_gnt) begin
            r_last <= SIDE_WR;
         end else if (w_rd_gnt) begin
            r_last <= SIDE_RD;
         end

         r_s1_valid <= w_rd_gnt;
         r_s1_oor   <= w_rd_gnt & ~w_rd_ok;
         r_s2_valid <= r_s1_valid;

         // An out-of-range read never enabled the RAM, so its data is forced to zero.
         if (r_s1_valid) begin
            r_rd_data <= r_s1_oor ? '0 : ram_rdata;
         end

         if ((w_wr_gnt && !w_wr_ok) || (w_rd_gnt && !w_rd_ok)) begin
            r_err_addr <= 1'b1;
         end
      end
   end

   assign wr_gnt   = w_wr_gnt;
   assign rd_gnt   = w_rd_gnt;
   assign rd_valid = r_s2_valid;
   assign rd_data  = r_rd_data;
   assign err_addr = r_err_addr;
   assign busy     = r_s1_valid | r_s2_valid;

endmodule
